cmn_list_alloc_ctrl: RTL and testbench

Registered multi-channel entry allocator for list/queue structures such as the ROB, free lists and issue-queue slots. It holds the busy vector and grants up to REQ_NUM free entries per cycle. Each grant reports a one-hot and a binary index. It retires up to REL_NUM entries per cycle. Scan order is selectable: LSB-first, MSB-first, or rotating from a pointer. A sticky error flags illegal releases.

---
 rtl/cmn_list_alloc_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_cmn_list_alloc_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmn_list_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// cmn_list_alloc_ctrl
//
// Multi-channel entry allocator for list and queue structures such as the
// ROB, free lists and issue-queue slots. It keeps a registered busy vector.
// Each cycle it can grant up to REQ_NUM free entries and retire up to
// REL_NUM busy entries.
//
// Grants are taken in order. Channel k receives the k-th free candidate, and
// only if every lower channel was granted as well. SCAN_MODE sets the order
// in which candidates are searched:
//   0 = LSB-first
//   1 = MSB-first
//   2 = rotating, starting at rr_ptr
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   flush             frees every entry next cycle; blocks grants this cycle
//   v_alloc_req       per-channel allocation request
//   v_alloc_gnt       per-channel grant (combinational)
//   v_alloc_idx_oh    per-channel one-hot index, zero when not granted
//   v_alloc_idx_bin   per-channel binary index, zero when not granted
//   v_rel_vld         per-channel release valid
//   v_rel_idx         per-channel binary index to release
//   v_entry_busy      registered busy vector
//   free_cnt          registered number of free entries
//   full, empty       free_cnt == 0 / free_cnt == ENTRY_NUM
//   rel_err           sticky flag for illegal releases
// ---------------------------------------------------------------------------
module cmn_list_alloc_ctrl #(
    parameter int ENTRY_NUM = 16,
    parameter int REQ_NUM   = 4,
    parameter int REL_NUM   = 4,
    parameter int SCAN_MODE = 0,
    localparam int AWIDTH   = $clog2(ENTRY_NUM),
    localparam int CWIDTH   = $clog2(ENTRY_NUM + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [REQ_NUM-1:0]                  v_alloc_req,
    output logic [REQ_NUM-1:0]                  v_alloc_gnt,
    output logic [REQ_NUM-1:0][ENTRY_NUM-1:0]   v_alloc_idx_oh,
    output logic [REQ_NUM-1:0][AWIDTH-1:0]      v_alloc_idx_bin,
    input  logic [REL_NUM-1:0]                  v_rel_vld,
    input  logic [REL_NUM-1:0][AWIDTH-1:0]      v_rel_idx,
    output logic [ENTRY_NUM-1:0]                v_entry_busy,
    output logic [CWIDTH-1:0]                   free_cnt,
    output logic                                full,
    output logic                                empty,
    output logic                                rel_err
);

    localparam logic [CWIDTH-1:0] ALL_FREE = CWIDTH'(ENTRY_NUM);

    // Registered state
    logic [ENTRY_NUM-1:0] busy_q, busy_d;
    logic [CWIDTH-1:0]    free_cnt_q, free_cnt_d;
    logic [AWIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic                 rel_err_q, rel_err_d;

    // Candidate search
    logic [ENTRY_NUM-1:0]            scan_vec;
    logic [AWIDTH-1:0]               rot_idx;
    logic [ENTRY_NUM-1:0]            scan_mask;
    logic [ENTRY_NUM-1:0]            scan_first;
    logic [AWIDTH-1:0]               scan_pos;
    logic [REQ_NUM-1:0]              cand_vld;
    logic [REQ_NUM-1:0][AWIDTH-1:0]  cand_idx;

    // Grant and release bookkeeping
    logic                 grant_chain;
    logic [ENTRY_NUM-1:0] alloc_set;
    logic [AWIDTH-1:0]    last_gnt_idx;
    logic [CWIDTH-1:0]    gnt_cnt;
    logic [REL_NUM-1:0]   rel_legal;
    logic [ENTRY_NUM-1:0] rel_clr;
    logic                 rel_bad;
    logic                 rel_dup;
    logic [CWIDTH-1:0]    rel_cnt;

    // Reorder the free vector so the preferred candidate is always at bit 0.
    // This lets one lowest-set-bit search serve all three scan modes. Scan
    // bit j maps to entry j (mode 0), to entry ENTRY_NUM-1-j (mode 1), or to
    // entry (j + rr_ptr) mod ENTRY_NUM (mode 2). In mode 2 the AWIDTH-bit
    // add supplies the wrap, because ENTRY_NUM is a power of two.
    always_comb begin
        scan_vec = '0;
        rot_idx  = '0;
        for (int j = 0; j < ENTRY_NUM; j++) begin
            rot_idx = AWIDTH'(j) + rr_ptr_q;
            case (SCAN_MODE)
                1:       scan_vec[j] = ~busy_q[ENTRY_NUM-1-j];
                2:       scan_vec[j] = ~busy_q[rot_idx];
                default: scan_vec[j] = ~busy_q[j];
            endcase
        end
    end

    // Iterative mask search. Isolate the lowest set bit (x & -x), encode it,
    // and XOR it out, once per channel. Each scan position is then mapped
    // back to a real entry index through the inverse of the reordering above.
    always_comb begin
        scan_mask  = scan_vec;
        scan_first = '0;
        scan_pos   = '0;
        cand_vld   = '0;
        cand_idx   = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            scan_first = scan_mask & (~scan_mask + ENTRY_NUM'(1));
            scan_pos   = '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (scan_first[i]) begin
                    scan_pos = AWIDTH'(i);
                end
            end
            cand_vld[k] = |scan_first;
            case (SCAN_MODE)
                1:       cand_idx[k] = AWIDTH'(ENTRY_NUM - 1) - scan_pos;
                2:       cand_idx[k] = scan_pos + rr_ptr_q;
                default: cand_idx[k] = scan_pos;
            endcase
            scan_mask = scan_mask ^ scan_first;
        end
    end

    // In-order grants. Once a channel is idle or denied, grant_chain drops
    // and every higher channel is refused, even if it requests and free
    // entries remain. This keeps channel k paired with the k-th candidate.
    // Flush suppresses all grants. last_gnt_idx ends up holding the index of
    // the highest granted channel, which feeds the rotating pointer.
    always_comb begin
        grant_chain     = 1'b1;
        v_alloc_gnt     = '0;
        v_alloc_idx_oh  = '0;
        v_alloc_idx_bin = '0;
        alloc_set       = '0;
        last_gnt_idx    = '0;
        gnt_cnt         = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (grant_chain && v_alloc_req[k] && cand_vld[k] && !flush) begin
                v_alloc_gnt[k]     = 1'b1;
                v_alloc_idx_bin[k] = cand_idx[k];
                v_alloc_idx_oh[k]  = ENTRY_NUM'(1) << cand_idx[k];
                alloc_set          = alloc_set | v_alloc_idx_oh[k];
                last_gnt_idx       = cand_idx[k];
                gnt_cnt            = gnt_cnt + CWIDTH'(1);
            end else begin
                grant_chain = 1'b0;
            end
        end
    end

    // Release qualification. A release is legal only if its entry is busy in
    // the registered state and no lower-numbered valid channel names the same
    // index. For a duplicate, the first channel frees the entry and each
    // later copy counts as illegal. Illegal releases only raise rel_bad.
    always_comb begin
        rel_legal = '0;
        rel_clr   = '0;
        rel_bad   = 1'b0;
        rel_dup   = 1'b0;
        rel_cnt   = '0;
        for (int r = 0; r < REL_NUM; r++) begin
            rel_dup = 1'b0;
            for (int j = 0; j < r; j++) begin
                if (v_rel_vld[j] && (v_rel_idx[j] == v_rel_idx[r])) begin
                    rel_dup = 1'b1;
                end
            end
            if (v_rel_vld[r]) begin
                if (busy_q[v_rel_idx[r]] && !rel_dup) begin
                    rel_legal[r]          = 1'b1;
                    rel_clr[v_rel_idx[r]] = 1'b1;
                    rel_cnt               = rel_cnt + CWIDTH'(1);
                end else begin
                    rel_bad = 1'b1;
                end
            end
        end
    end

    // Next-state computation. Flush takes priority over grants and releases.
    // rel_err still accumulates during a flush, so a bad release issued with
    // a flush is not lost. Grants only ever pick free entries and releases
    // only ever clear busy ones, so the set and clear masks never overlap.
    // The free count can therefore never wrap.
    always_comb begin
        busy_d     = busy_q;
        free_cnt_d = free_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        rel_err_d  = rel_err_q | rel_bad;
        if (flush) begin
            busy_d     = '0;
            free_cnt_d = ALL_FREE;
            rr_ptr_d   = '0;
        end else begin
            busy_d     = (busy_q | alloc_set) & ~rel_clr;
            free_cnt_d = free_cnt_q - gnt_cnt + rel_cnt;
            if ((SCAN_MODE == 2) && (|v_alloc_gnt)) begin
                rr_ptr_d = last_gnt_idx + AWIDTH'(1);
            end
        end
    end

    // State registers, cleared asynchronously so that the outputs return to
    // idle as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            free_cnt_q <= ALL_FREE;
            rr_ptr_q   <= '0;
            rel_err_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rel_err_q  <= rel_err_d;
        end
    end

    assign v_entry_busy = busy_q;
    assign free_cnt     = free_cnt_q;
    assign full         = (free_cnt_q == '0);
    assign empty        = (free_cnt_q == ALL_FREE);
    assign rel_err      = rel_err_q;

endmodule

// File: tb/tb_cmn_list_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmn_list_alloc_ctrl
//
// Directed bench for cmn_list_alloc_ctrl. It builds one instance per scan
// mode (LSB-first, MSB-first, rotating), and all three share the same input
// stimulus. Each scenario resets the instances first, so only the instance
// under study needs meaningful history. Expected values are hand-computed
// for ENTRY_NUM=16, REQ_NUM=4, REL_NUM=4.
// ---------------------------------------------------------------------------
module tb_cmn_list_alloc_ctrl;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [3:0]       req;
    logic [3:0]       rel_vld;
    logic [3:0][3:0]  rel_idx;

    logic [3:0]       gnt0, gnt1, gnt2;
    logic [3:0][15:0] oh0, oh1, oh2;
    logic [3:0][3:0]  bin0, bin1, bin2;
    logic [15:0]      busy0, busy1, busy2;
    logic [4:0]       fc0, fc1, fc2;
    logic             full0, full1, full2;
    logic             empty0, empty1, empty2;
    logic             err0, err1, err2;

    int n_checks;
    int n_fail;

    cmn_list_alloc_ctrl #(.ENTRY_NUM(16), .REQ_NUM(4), .REL_NUM(4), .SCAN_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .v_alloc_req(req), .v_alloc_gnt(gnt0),
        .v_alloc_idx_oh(oh0), .v_alloc_idx_bin(bin0), .v_rel_vld(rel_vld), .v_rel_idx(rel_idx),
        .v_entry_busy(busy0), .free_cnt(fc0), .full(full0), .empty(empty0), .rel_err(err0)
    );

    cmn_list_alloc_ctrl #(.ENTRY_NUM(16), .REQ_NUM(4), .REL_NUM(4), .SCAN_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .v_alloc_req(req), .v_alloc_gnt(gnt1),
        .v_alloc_idx_oh(oh1), .v_alloc_idx_bin(bin1), .v_rel_vld(rel_vld), .v_rel_idx(rel_idx),
        .v_entry_busy(busy1), .free_cnt(fc1), .full(full1), .empty(empty1), .rel_err(err1)
    );

    cmn_list_alloc_ctrl #(.ENTRY_NUM(16), .REQ_NUM(4), .REL_NUM(4), .SCAN_MODE(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .v_alloc_req(req), .v_alloc_gnt(gnt2),
        .v_alloc_idx_oh(oh2), .v_alloc_idx_bin(bin2), .v_rel_vld(rel_vld), .v_rel_idx(rel_idx),
        .v_entry_busy(busy2), .free_cnt(fc2), .full(full2), .empty(empty2), .rel_err(err2)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge, away from the sampling point
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Return every input to its inactive value
    task automatic idle_inputs;
        req     = '0;
        rel_vld = '0;
        rel_idx = '0;
        flush   = 1'b0;
    endtask

    // Pulse the asynchronous reset between clock edges
    task automatic do_reset;
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    // Check the idle state left behind by reset
    task automatic test_reset;
        do_reset();
        #1;
        n_checks++; if (busy0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_busy: got %h expected 0000", busy0); end
        n_checks++; if (fc0 !== 5'd16) begin n_fail++; $display("[TB] FAIL reset_free_cnt: got %0d expected 16", fc0); end
        n_checks++; if (full0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", full0); end
        n_checks++; if (empty0 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", empty0); end
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rel_err: got %b expected 0", err0); end
        n_checks++; if (gnt0 !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_idle_gnt: got %b expected 0000", gnt0); end
    endtask

    // LSB-first scan on an empty pool
    task automatic test_mode0_alloc;
        do_reset();
        req = 4'b1111;
        #1;
        n_checks++; if (gnt0 !== 4'b1111) begin n_fail++; $display("[TB] FAIL m0_gnt: got %b expected 1111", gnt0); end
        n_checks++; if (bin0 !== 16'h3210) begin n_fail++; $display("[TB] FAIL m0_bin: got %h expected 3210", bin0); end
        n_checks++; if (oh0 !== 64'h0008_0004_0002_0001) begin n_fail++; $display("[TB] FAIL m0_oh: got %h expected 0008000400020001", oh0); end
        tick();
        req = 4'b0000;
        #1;
        n_checks++; if (busy0 !== 16'h000F) begin n_fail++; $display("[TB] FAIL m0_busy: got %h expected 000f", busy0); end
        n_checks++; if (fc0 !== 5'd12) begin n_fail++; $display("[TB] FAIL m0_free_cnt: got %0d expected 12", fc0); end
        n_checks++; if (empty0 !== 1'b0) begin n_fail++; $display("[TB] FAIL m0_empty: got %b expected 0", empty0); end
    endtask

    // MSB-first scan, with channel 3 idle
    task automatic test_mode1_alloc;
        do_reset();
        req = 4'b0111;
        #1;
        n_checks++; if (gnt1 !== 4'b0111) begin n_fail++; $display("[TB] FAIL m1_gnt: got %b expected 0111", gnt1); end
        n_checks++; if (bin1 !== 16'h0DEF) begin n_fail++; $display("[TB] FAIL m1_bin: got %h expected 0def", bin1); end
        n_checks++; if (oh1[3] !== 16'h0000) begin n_fail++; $display("[TB] FAIL m1_oh_idle: got %h expected 0000", oh1[3]); end
        n_checks++; if (oh1[0] !== 16'h8000) begin n_fail++; $display("[TB] FAIL m1_oh_ch0: got %h expected 8000", oh1[0]); end
        tick();
        req = 4'b0000;
        #1;
        n_checks++; if (busy1 !== 16'hE000) begin n_fail++; $display("[TB] FAIL m1_busy: got %h expected e000", busy1); end
        n_checks++; if (fc1 !== 5'd13) begin n_fail++; $display("[TB] FAIL m1_free_cnt: got %0d expected 13", fc1); end
    endtask

    // Rotating scan. The pointer moves past the last grant, so freed entry 1
    // is skipped.
    task automatic test_mode2_rotate;
        do_reset();
        req = 4'b1111;
        #1;
        n_checks++; if (bin2 !== 16'h3210) begin n_fail++; $display("[TB] FAIL m2_first_bin: got %h expected 3210", bin2); end
        tick();
        req        = 4'b0000;
        rel_vld    = 4'b0001;
        rel_idx[0] = 4'd1;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy2 !== 16'h000D) begin n_fail++; $display("[TB] FAIL m2_busy_after_rel: got %h expected 000d", busy2); end
        n_checks++; if (fc2 !== 5'd13) begin n_fail++; $display("[TB] FAIL m2_free_after_rel: got %0d expected 13", fc2); end
        req = 4'b1111;
        #1;
        n_checks++; if (gnt2 !== 4'b1111) begin n_fail++; $display("[TB] FAIL m2_gnt: got %b expected 1111", gnt2); end
        n_checks++; if (bin2 !== 16'h7654) begin n_fail++; $display("[TB] FAIL m2_bin: got %h expected 7654", bin2); end
        tick();
        req = 4'b0000;
        #1;
        n_checks++; if (fc2 !== 5'd9) begin n_fail++; $display("[TB] FAIL m2_free_cnt: got %0d expected 9", fc2); end
        n_checks++; if (busy2 !== 16'h00FD) begin n_fail++; $display("[TB] FAIL m2_busy: got %h expected 00fd", busy2); end
        req = 4'b0001;
        #1;
        n_checks++; if (bin2[0] !== 4'd8) begin n_fail++; $display("[TB] FAIL m2_rr_ptr_8: got %0d expected 8", bin2[0]); end
        idle_inputs();
    endtask

    // Near-full pool. Only entries 5 and 9 are free, then the pool is full.
    task automatic test_fill_full;
        do_reset();
        req = 4'b1111;
        repeat (4) tick();
        req = 4'b0000;
        #1;
        n_checks++; if (full0 !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_full_first: got %b expected 1", full0); end
        rel_vld    = 4'b0011;
        rel_idx[0] = 4'd5;
        rel_idx[1] = 4'd9;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy0 !== 16'hFDDF) begin n_fail++; $display("[TB] FAIL fill_busy14: got %h expected fddf", busy0); end
        n_checks++; if (fc0 !== 5'd2) begin n_fail++; $display("[TB] FAIL fill_free2: got %0d expected 2", fc0); end
        req = 4'b1111;
        #1;
        n_checks++; if (gnt0 !== 4'b0011) begin n_fail++; $display("[TB] FAIL fill_gnt: got %b expected 0011", gnt0); end
        n_checks++; if (bin0 !== 16'h0095) begin n_fail++; $display("[TB] FAIL fill_bin: got %h expected 0095", bin0); end
        tick();
        req = 4'b0000;
        #1;
        n_checks++; if (full0 !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_full: got %b expected 1", full0); end
        n_checks++; if (fc0 !== 5'd0) begin n_fail++; $display("[TB] FAIL fill_free0: got %0d expected 0", fc0); end
        req = 4'b0001;
        #1;
        n_checks++; if (gnt0 !== 4'b0000) begin n_fail++; $display("[TB] FAIL fill_no_gnt: got %b expected 0000", gnt0); end
        idle_inputs();
    endtask

    // Request gaps, release of a free entry, and duplicate release indices
    task automatic test_gap_and_illegal;
        do_reset();
        req = 4'b1101;
        #1;
        n_checks++; if (gnt0 !== 4'b0001) begin n_fail++; $display("[TB] FAIL gap_gnt: got %b expected 0001", gnt0); end
        n_checks++; if (bin0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL gap_bin: got %h expected 0000", bin0); end
        n_checks++; if (oh0[2] !== 16'h0000) begin n_fail++; $display("[TB] FAIL gap_oh2: got %h expected 0000", oh0[2]); end
        tick();
        req        = 4'b0000;
        rel_vld    = 4'b0001;
        rel_idx[0] = 4'd7;
        #1;
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("[TB] FAIL free_rel_err_before: got %b expected 0", err0); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy0 !== 16'h0001) begin n_fail++; $display("[TB] FAIL free_rel_busy: got %h expected 0001", busy0); end
        n_checks++; if (fc0 !== 5'd15) begin n_fail++; $display("[TB] FAIL free_rel_cnt: got %0d expected 15", fc0); end
        n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("[TB] FAIL free_rel_err: got %b expected 1", err0); end

        do_reset();
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clear_on_rst: got %b expected 0", err0); end
        req = 4'b1111;
        tick();
        req        = 4'b0000;
        rel_vld    = 4'b0011;
        rel_idx[0] = 4'd3;
        rel_idx[1] = 4'd3;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (fc0 !== 5'd13) begin n_fail++; $display("[TB] FAIL dup_free_cnt: got %0d expected 13", fc0); end
        n_checks++; if (busy0 !== 16'h0007) begin n_fail++; $display("[TB] FAIL dup_busy: got %h expected 0007", busy0); end
        n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("[TB] FAIL dup_err: got %b expected 1", err0); end
        tick();
        n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b expected 1", err0); end
    endtask

    // Grant and release of different entries in the same cycle
    task automatic test_back_to_back;
        do_reset();
        req = 4'b1111;
        tick();
        req        = 4'b0001;
        rel_vld    = 4'b0001;
        rel_idx[0] = 4'd0;
        #1;
        n_checks++; if (bin0[0] !== 4'd4) begin n_fail++; $display("[TB] FAIL b2b_bin_first: got %0d expected 4", bin0[0]); end
        tick();
        rel_idx[0] = 4'd4;
        #1;
        n_checks++; if (busy0 !== 16'h001E) begin n_fail++; $display("[TB] FAIL b2b_busy_first: got %h expected 001e", busy0); end
        n_checks++; if (fc0 !== 5'd12) begin n_fail++; $display("[TB] FAIL b2b_cnt_first: got %0d expected 12", fc0); end
        n_checks++; if (bin0[0] !== 4'd0) begin n_fail++; $display("[TB] FAIL b2b_reuse_freed: got %0d expected 0", bin0[0]); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy0 !== 16'h000F) begin n_fail++; $display("[TB] FAIL b2b_busy_second: got %h expected 000f", busy0); end
        n_checks++; if (fc0 !== 5'd12) begin n_fail++; $display("[TB] FAIL b2b_cnt_second: got %0d expected 12", fc0); end
    endtask

    // Flush with requests and releases pending
    task automatic test_flush;
        do_reset();
        req = 4'b1111;
        tick();
        flush      = 1'b1;
        rel_vld    = 4'b0001;
        rel_idx[0] = 4'd0;
        #1;
        n_checks++; if (gnt0 !== 4'b0000) begin n_fail++; $display("[TB] FAIL flush_gnt0: got %b expected 0000", gnt0); end
        n_checks++; if (gnt2 !== 4'b0000) begin n_fail++; $display("[TB] FAIL flush_gnt2: got %b expected 0000", gnt2); end
        n_checks++; if (oh0 !== 64'h0) begin n_fail++; $display("[TB] FAIL flush_oh: got %h expected 0", oh0); end
        n_checks++; if (bin0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL flush_bin: got %h expected 0000", bin0); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (busy0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL flush_busy: got %h expected 0000", busy0); end
        n_checks++; if (fc0 !== 5'd16) begin n_fail++; $display("[TB] FAIL flush_free_cnt: got %0d expected 16", fc0); end
        n_checks++; if (empty0 !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_empty: got %b expected 1", empty0); end
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_err: got %b expected 0", err0); end
        n_checks++; if (busy2 !== 16'h0000) begin n_fail++; $display("[TB] FAIL flush_busy_m2: got %h expected 0000", busy2); end
        req = 4'b0001;
        #1;
        n_checks++; if (bin2[0] !== 4'd0) begin n_fail++; $display("[TB] FAIL flush_rr_ptr: got %0d expected 0", bin2[0]); end
        n_checks++; if (gnt2 !== 4'b0001) begin n_fail++; $display("[TB] FAIL flush_regrant: got %b expected 0001", gnt2); end
        idle_inputs();
    endtask

    // Asynchronous reset raised mid-cycle, with traffic and rel_err set
    task automatic test_async_reset;
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        req        = 4'b0000;
        rel_vld    = 4'b0001;
        rel_idx[0] = 4'd12;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_pre_err: got %b expected 1", err0); end
        n_checks++; if (fc0 !== 5'd8) begin n_fail++; $display("[TB] FAIL ar_pre_cnt: got %0d expected 8", fc0); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL ar_busy: got %h expected 0000", busy0); end
        n_checks++; if (fc0 !== 5'd16) begin n_fail++; $display("[TB] FAIL ar_free_cnt: got %0d expected 16", fc0); end
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_err: got %b expected 0", err0); end
        n_checks++; if (empty0 !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_empty: got %b expected 1", empty0); end
        n_checks++; if (busy2 !== 16'h0000) begin n_fail++; $display("[TB] FAIL ar_busy_m2: got %h expected 0000", busy2); end
        #1;
        rst = 1'b0;
        #1;
    endtask

    // Run every scenario in order
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        #12;
        rst = 1'b0;
        test_reset();
        test_mode0_alloc();
        test_mode1_alloc();
        test_mode2_rotate();
        test_fill_full();
        test_gap_and_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
